// File: rtl/word_reconstructor.sv
// Rebuilds 32-bit words from compressed tokens (match type, dictionary index, literal bytes)
// using a FIFO-replacement dictionary that tracks the compressor's own update rule.
module word_reconstructor #(
  parameter int DICT_DEPTH = 16,
  parameter int IDX_W      = $clog2(DICT_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_match_type,
  input  logic [IDX_W-1:0] i_dict_idx,
  input  logic [31:0]      i_literal,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_word,
  output logic             o_err,
  output logic [IDX_W:0]   o_dict_count
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DICT_DEPTH);

  logic [31:0]           r_dict [DICT_DEPTH];
  logic [DICT_DEPTH-1:0] r_dvalid;
  logic [IDX_W-1:0]      r_wr_ptr;
  logic [IDX_W:0]        r_count;
  logic                  r_valid;
  logic [31:0]           r_word;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_insert;
  logic [31:0]           w_dpart;
  logic                  w_miss;
  logic [31:0]           w_word;
  logic                  w_err;

  assign o_ready      = !i_clear && (!r_valid || i_ready);
  assign w_accept     = i_valid && o_ready;
  assign w_insert     = w_accept && (i_match_type != 2'd3);
  assign o_valid      = r_valid;
  assign o_word       = r_word;
  assign o_err        = r_err;
  assign o_dict_count = r_count;

  // Slots never written since reset/clear contribute zeros and flag the word as erroneous.
  always_comb begin
    w_miss  = !r_dvalid[i_dict_idx];
    w_dpart = w_miss ? 32'd0 : r_dict[i_dict_idx];
    w_word  = i_literal;
    w_err   = 1'b0;
    case (i_match_type)
      2'd1: begin
        w_word = {w_dpart[31:16], i_literal[15:0]};
        w_err  = w_miss;
      end
      2'd2: begin
        w_word = {w_dpart[31:8], i_literal[7:0]};
        w_err  = w_miss;
      end
      2'd3: begin
        w_word = w_dpart;
        w_err  = w_miss;
      end
      default: begin
        w_word = i_literal;
        w_err  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid  <= 1'b0;
      r_word   <= 32'd0;
      r_err    <= 1'b0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_dvalid <= '0;
      for (int i = 0; i < DICT_DEPTH; i++) r_dict[i] <= 32'd0;
    end else if (i_clear) begin
      // Entry data is left in place; clearing the valid bits is enough to invalidate it.
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_dvalid <= '0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_word  <= w_word;
        r_err   <= w_err;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
      if (w_insert) begin
        r_dict[r_wr_ptr]   <= w_word;
        r_dvalid[r_wr_ptr] <= 1'b1;
        r_wr_ptr           <= r_wr_ptr + 1'b1;
        if (r_count != FULL_CNT) r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/word_reconstructor.md
Name: word_reconstructor

Overview:
- Decompression-side counterpart of the compressor's per-word match classification.
- Accepts one compressed token per handshake: a match type, a dictionary index and literal bytes. Rebuilds the original 32-bit word from its own dictionary plus the literals.
- Maintains a FIFO-replacement dictionary that mirrors the compressor's update rule. Delivers reconstructed words through a registered valid/ready output stage.

Parameters:
- DICT_DEPTH, 16, number of dictionary entries; power of two, >= 2.
- IDX_W, $clog2(DICT_DEPTH), index width; derived, do not override.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_clear  input  1  synchronous dictionary/pipeline flush.
- i_valid  input  1  token valid.
- o_ready  output  1  token accepted when i_valid && o_ready.
- i_match_type  input  2  0 = miss (4 literal bytes); 1 = bytes[31:16] from dictionary; 2 = bytes[31:8] from dictionary; 3 = full match.
- i_dict_idx  input  IDX_W  absolute dictionary slot; ignored for type 0.
- i_literal  input  32  literal bytes right-aligned. Type 0 uses [31:0], type 1 uses [15:0], type 2 uses [7:0], type 3 uses none.
- o_valid  output  1  reconstructed word valid.
- i_ready  input  1  downstream accepts when o_valid && i_ready.
- o_word  output  32  reconstructed word.
- o_err  output  1  qualifies o_word; token referenced a slot never written since reset/clear.
- o_dict_count  output  IDX_W+1  number of valid dictionary entries, 0..DICT_DEPTH.

Behaviour:
- Reset (i_rst_n low, async): o_valid=0, o_word=0, o_err=0, o_dict_count=0, write pointer=0, all dictionary entries=0, all entry-valid bits=0.
- o_ready = !i_clear && (!o_valid || i_ready). This is combinational, giving a single output stage with no skid buffer.
- Accept = i_valid && o_ready. Latency is 1 cycle: the word for a token accepted at edge N is on o_word with o_valid=1 after edge N.
- Reconstruction reads the dictionary combinationally from current register contents in the accept cycle:
  - Type 0: word = i_literal.
  - Type 1: word = {D[idx][31:16], i_literal[15:0]}.
  - Type 2: word = {D[idx][31:8], i_literal[7:0]}.
  - Type 3: word = D[idx].
- Error: for types 1-3 with an entry-valid bit of 0, the dictionary portion is forced to 0 and o_err=1 is registered with the word. The token is otherwise processed normally. Type 0 always has o_err=0.
- Dictionary update on accept, at the same edge as the output register load:
  - Types 0, 1, 2: D[wr_ptr] <= reconstructed word, its valid bit is set, and wr_ptr <= wr_ptr+1 modulo DICT_DEPTH (wraps). o_dict_count increments, saturating at DICT_DEPTH.
  - Type 3: no insert; wr_ptr and count unchanged.
- Read-after-write: a token accepted in the cycle after an insert sees the new entry. There is no forwarding hazard, because the write completes at the accept edge.
- Overwrite at wrap: the oldest slot is replaced. An index to that slot returns the new word.
- Output stage:
  - When o_valid && !i_ready and there is no accept, o_word and o_err hold stable.
  - When o_valid && i_ready and there is no accept, o_valid clears next cycle; o_word holds its last value.
- i_clear (synchronous, highest priority after reset) sets o_valid=0, o_err=0, wr_ptr=0, o_dict_count=0 and all valid bits to 0 at the next edge. Entry data may remain.
- While i_clear is high, o_ready=0, so no token is accepted that cycle. Any pending output word is dropped.
- Asynchronous reset mid-stream discards the pending output and dictionary immediately, with no partial update.

Test Plan:
- Reset: assert i_rst_n=0 mid-run -> o_valid=0, o_word=0, o_err=0, o_dict_count=0 immediately, without waiting for a clock edge.
- Literal then matches:
  - Type 0, literal 0xDEADBEEF -> next cycle o_word=0xDEADBEEF, o_err=0, count=1.
  - Then type 3, idx 0 -> 0xDEADBEEF, count stays 1.
  - Then type 1, idx 0, literal 0x00001234 -> 0xDEAD1234, count=2.
  - Then type 2, idx 1, literal 0x56 -> 0xDEAD1256, count=3.
- Backpressure: with o_valid=1, hold i_ready=0 for 3 cycles while i_valid=1 -> o_ready=0, o_word stable, count unchanged. When i_ready=1 resumes, the stream continues with no loss or duplication.
- Wrap: 17 type-0 literals 0x1000_0000+n (n=0..16) -> count saturates at 16. Slot 0 holds 0x1000_0010; type 3 idx 0 returns 0x10000010 and type 3 idx 1 returns 0x10000001.
- Error: after i_clear, send type 3 idx 5 -> o_word=0, o_err=1, count=0. Send type 2 idx 0, literal 0xAB -> o_word=0x000000AB, o_err=1, count=1.
- Clear collision: i_clear=1 with i_valid=1 and o_valid=1 -> o_ready=0, token not accepted. Next cycle o_valid=0 and count=0; the same token presented afterwards is processed against an empty dictionary.
